pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush/run controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards and ID-stage branch operand hazards that forwarding cannot cover.
//  - Squashes wrong-path instructions after ID redirects (BEQ taken, JAL) and EX redirects (JALR).
//  - Provides HALT / single-STEP debug sequencing and saturating stall/flush performance counters.
//  - Drives the enable and flush inputs of PC, IFID, IDEX, EXMEM and MEMWB.
// PARAMETERS
//  CNT_W   32   width of stall_cnt and flush_cnt
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  enable       in   1      global run enable; 0 freezes the whole pipeline
//  halt_req     in   1      level; 1 requests/holds the HALT state
//  step_req     in   1      pulse; in HALT, advance the pipeline exactly one cycle
//  id_rs1       in   5      instr[19:15] in ID
//  id_rs2       in   5      instr[24:20] in ID
//  id_use_rs1   in   1      ID instruction reads rs1
//  id_use_rs2   in   1      ID instruction reads rs2
//  id_branch    in   1      ID instruction is BEQ (compares in ID)
//  id_redirect  in   1      ID redirect: (branch & equal) | JAL
//  ex_redirect  in   1      JALR in EX (pcsrc[1] registered in IDEX)
//  ex_rd        in   5      IDEX destination register
//  ex_regwrite  in   1      IDEX regwrite
//  ex_memread   in   1      IDEX memread
//  mem_rd       in   5      EXMEM destination register
//  mem_memread  in   1      EXMEM memread
//  pc_en, ifid_en, idex_en, exmem_en, memwb_en   out 1   stage-register load enables
//  ifid_flush   out  1      clear IFID to NOP on the next edge (overrides ifid_en)
//  idex_flush   out  1      clear IDEX to bubble (all controls 0) on the next edge (overrides idex_en)
//  halted       out  1      1 while state==HALT
//  stall_cnt    out  CNT_W  cycles spent in hazard stall, saturating
//  flush_cnt    out  CNT_W  redirect events, saturating
// BEHAVIOUR
//  - Reset (sync): state=RUN, stall_cnt=0, flush_cnt=0.
//  - FSM states:
//    RUN  -> HALT when halt_req=1.
//    HALT -> STEP when step_req=1 and halt_req=1.
//    HALT -> RUN when halt_req=0.
//    STEP -> HALT always after one cycle.
//    The FSM holds while enable=0.
//  - Advancing cycle ("adv") = (state==RUN & ~halt_req) | state==STEP, qualified by enable=1.
//  - When not adv: all five enables=0, both flushes=0, counters hold; halt takes effect in the same cycle halt_req rises.
//  - Match rule: a source rsN matches register r when id_use_rsN=1 and rsN==r and r!=0. x0 never creates a hazard.
//  - Stall condition (combinational, evaluated every adv cycle):
//    a) load-use: ex_memread & ex_rd matches rs1/rs2.
//    b) id_branch & ex_regwrite & ex_rd matches (covers ALU results and loads; a load stalls 2 cycles via a then c).
//    c) id_branch & mem_memread & mem_rd matches.
//  - Priority (highest first): ex_redirect, then stall, then id_redirect.
//    - ex_redirect: ifid_flush=1, idex_flush=1, pc_en=1; stall and id_redirect are ignored; flush_cnt+1.
//    - stall: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stall_cnt+1. An id_redirect in this cycle is ignored (operands stale).
//    - id_redirect: pc_en=1, ifid_flush=1 (one slot squashed); flush_cnt+1.
//    - Otherwise: all enables=1, flushes=0.
//  - All outputs except counters/halted are combinational from state and inputs: zero added latency.
//  - Counters saturate at all-ones and never wrap.
//  - Reset mid-stall or mid-STEP returns to RUN with counters cleared; no residual stall state.
// TESTING
//  - lw x5,0(x0); add x6,x5,x1 -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
//  - lw x5; beq x5,x2 -> 2 consecutive stall cycles (rules a then c); stall_cnt=2; the branch then resolves.
//  - add x7,...; beq x7,x0 taken -> 1 stall, then ifid_flush=1 in the resolve cycle; flush_cnt=1.
//  - ex_redirect=1 with a load-use hazard and id_redirect both present -> ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged.
//  - halt_req=1 for 5 cycles with two step_req pulses -> exactly 2 cycles with all enables=1; halted=1 otherwise; halt_req=0 -> RUN.
//  - ex_rd=0 with ex_memread=1 and id_rs1=0 -> no stall; reset asserted during a stall -> next cycle RUN with counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / run controller for a 5-stage RISC-V pipeline.
// Detects hazards that forwarding cannot cover, squashes wrong-path
// instructions after redirects, sequences HALT / single-STEP debug and
// keeps saturating stall and flush event counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_branch,
  input  logic             id_redirect,
  input  logic             ex_redirect,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_memread,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t state, state_next;

  logic adv;
  logic hazard;
  logic stall_inc;
  logic flush_inc;

  // True when the ID instruction reads register r through an active source.
  // x0 is hardwired to zero and can never carry a hazard.
  function automatic logic id_reads(input logic [4:0] r);
    return (r != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == r)) || (id_use_rs2 && (id_rs2 == r)));
  endfunction

  // Debug sequencing: next state; everything freezes while enable is low.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely
    // combinational; a path that left state_next unassigned would infer a latch.
    state_next = state;
    if (enable) begin
      unique case (state)
        ST_RUN:  if (halt_req) state_next = ST_HALT;
        ST_HALT: begin
          if (!halt_req)     state_next = ST_RUN;
          else if (step_req) state_next = ST_STEP;
        end
        ST_STEP: state_next = ST_HALT;
        default: state_next = ST_RUN;
      endcase
    end
  end

  // Hazard detection and stage-register control, prioritised
  // ex_redirect > stall > id_redirect.
  always_comb begin
    // halt_req gates RUN directly so a halt freezes the pipe in its first cycle.
    adv = enable && (((state == ST_RUN) && !halt_req) || (state == ST_STEP));

    // A load stalls a dependent branch twice: once in EX (via regwrite) and
    // once more in MEM, since load data is only forwardable from WB.
    hazard = (ex_memread && id_reads(ex_rd)) ||
             (id_branch && ex_regwrite && id_reads(ex_rd)) ||
             (id_branch && mem_memread && id_reads(mem_rd));

    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (adv) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (ex_redirect) begin
        // JALR resolved in EX: both younger instructions are wrong-path.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (hazard) begin
        // Hold PC and IFID, inject a bubble into EX; id_redirect was computed
        // from stale operands, so it is ignored this cycle.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end else if (id_redirect) begin
        ifid_flush = 1'b1;
        flush_inc  = 1'b1;
      end
    end
  end

  assign halted = (state == ST_HALT);

  // State register and saturating event counters, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register update from the
    // values present before the edge, regardless of statement order.
    if (reset) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios from the
// pipeline's hazard cases plus a randomized run against a behavioural model.
// A second instance with 4-bit counters exercises counter saturation.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       enable;
    logic       halt_req;
    logic       step_req;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_branch;
    logic       id_redirect;
    logic       ex_redirect;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] mem_rd;
    logic       mem_memread;
  } stim_t;

  // Control vector order: pc, ifid, idex, exmem, memwb enables, ifid/idex flush.
  localparam logic [6:0] CTL_FROZEN = 7'b0000000;
  localparam logic [6:0] CTL_RUN    = 7'b1111100;
  localparam logic [6:0] CTL_STALL  = 7'b0011101;
  localparam logic [6:0] CTL_IDRED  = 7'b1111110;
  localparam logic [6:0] CTL_EXRED  = 7'b1111111;

  logic clk, reset;
  logic enable, halt_req, step_req;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic id_use_rs1, id_use_rs2, id_branch, id_redirect, ex_redirect;
  logic ex_regwrite, ex_memread, mem_memread;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic s_ifid_flush, s_idex_flush, s_halted;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  logic [6:0] ctl, s_ctl;
  assign ctl   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
  assign s_ctl = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en, s_ifid_flush, s_idex_flush};

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .halt_req(halt_req), .step_req(step_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_branch(id_branch), .id_redirect(id_redirect), .ex_redirect(ex_redirect),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_memread(mem_memread),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .enable(enable), .halt_req(halt_req), .step_req(step_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_branch(id_branch), .id_redirect(id_redirect), .ex_redirect(ex_redirect),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_memread(mem_memread),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s = '0;
    s.enable = 1'b1;
    return s;
  endfunction

  task automatic set_in(input stim_t s);
    enable = s.enable; halt_req = s.halt_req; step_req = s.step_req;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_use_rs1 = s.id_use_rs1; id_use_rs2 = s.id_use_rs2;
    id_branch = s.id_branch; id_redirect = s.id_redirect; ex_redirect = s.ex_redirect;
    ex_rd = s.ex_rd; ex_regwrite = s.ex_regwrite; ex_memread = s.ex_memread;
    mem_rd = s.mem_rd; mem_memread = s.mem_memread;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(idle());
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++;
    if (halted !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state halted=%b stall=%0d flush=%0d exp 0/0/0", halted, stall_cnt, flush_cnt);
    end
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("FAIL reset_run_ctl got=%b exp=%b", ctl, CTL_RUN);
    end
  endtask

  // lw x5,0(x0) in EX; add x6,x5,x1 in ID.
  task automatic test_load_use();
    stim_t s;
    do_reset();
    s = idle();
    s.id_rs1 = 5'd5; s.id_rs2 = 5'd1; s.id_use_rs1 = 1'b1; s.id_use_rs2 = 1'b1;
    s.ex_rd = 5'd5; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
    set_in(s); #2;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL load_use_stall got=%b exp=%b", ctl, CTL_STALL);
    end
    tick();
    // Load now in MEM, bubble in EX: a non-branch consumer gets forwarding.
    s.ex_rd = 5'd0; s.ex_memread = 1'b0; s.ex_regwrite = 1'b0;
    s.mem_rd = 5'd5; s.mem_memread = 1'b1;
    set_in(s); #2;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("FAIL load_use_release got=%b exp=%b", ctl, CTL_RUN);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++; $display("FAIL load_use_count got=%0d exp=1", stall_cnt);
    end
  endtask

  // lw x5 in EX; beq x5,x2 in ID: stall in EX then again in MEM.
  task automatic test_branch_after_load();
    stim_t s;
    logic [6:0] exp [3] = '{CTL_STALL, CTL_STALL, CTL_RUN};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      s = idle();
      s.id_rs1 = 5'd5; s.id_rs2 = 5'd2; s.id_use_rs1 = 1'b1; s.id_use_rs2 = 1'b1;
      s.id_branch = 1'b1;
      if (c == 0) begin s.ex_rd = 5'd5; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1; end
      if (c == 1) begin s.mem_rd = 5'd5; s.mem_memread = 1'b1; end
      set_in(s); #2;
      checks++;
      if (ctl !== exp[c]) begin
        errors++; $display("FAIL branch_load_cycle%0d got=%b exp=%b", c, ctl, exp[c]);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 32'd2 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL branch_load_counts stall=%0d flush=%0d exp 2/0", stall_cnt, flush_cnt);
    end
  endtask

  // add x7 in EX; beq x7,x0 taken in ID. The stale redirect during the stall
  // must be ignored; the real one squashes one slot.
  task automatic test_branch_after_alu();
    stim_t s;
    do_reset();
    s = idle();
    s.id_rs1 = 5'd7; s.id_rs2 = 5'd0; s.id_use_rs1 = 1'b1; s.id_use_rs2 = 1'b1;
    s.id_branch = 1'b1; s.id_redirect = 1'b1;
    s.ex_rd = 5'd7; s.ex_regwrite = 1'b1;
    set_in(s); #2;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL branch_alu_stall got=%b exp=%b", ctl, CTL_STALL);
    end
    tick();
    s.ex_rd = 5'd0; s.ex_regwrite = 1'b0; s.mem_rd = 5'd7;
    set_in(s); #2;
    checks++;
    if (ctl !== CTL_IDRED) begin
      errors++; $display("FAIL branch_alu_resolve got=%b exp=%b", ctl, CTL_IDRED);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
      errors++; $display("FAIL branch_alu_counts stall=%0d flush=%0d exp 1/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_ex_redirect_priority();
    stim_t s;
    do_reset();
    s = idle();
    s.ex_redirect = 1'b1; s.id_redirect = 1'b1;
    s.id_rs1 = 5'd3; s.id_use_rs1 = 1'b1; s.ex_rd = 5'd3; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
    set_in(s); #2;
    checks++;
    if (ctl !== CTL_EXRED) begin
      errors++; $display("FAIL ex_redirect_ctl got=%b exp=%b", ctl, CTL_EXRED);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd1) begin
      errors++; $display("FAIL ex_redirect_counts stall=%0d flush=%0d exp 0/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_x0_no_hazard();
    stim_t s;
    do_reset();
    s = idle();
    s.id_rs1 = 5'd0; s.id_use_rs1 = 1'b1; s.id_branch = 1'b1;
    s.ex_rd = 5'd0; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
    s.mem_rd = 5'd0; s.mem_memread = 1'b1;
    set_in(s); #2;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("FAIL x0_no_stall got=%b exp=%b", ctl, CTL_RUN);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++; $display("FAIL x0_count got=%0d exp=0", stall_cnt);
    end
  endtask

  // halt_req high for 5 cycles with step pulses in cycles 2 and 4, then low.
  task automatic test_halt_step();
    stim_t s;
    logic       hreq [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic       sreq [8] = '{0, 0, 1, 0, 1, 0, 0, 0};
    logic [6:0] exp  [8] = '{CTL_FROZEN, CTL_FROZEN, CTL_FROZEN, CTL_RUN,
                             CTL_FROZEN, CTL_RUN, CTL_FROZEN, CTL_RUN};
    logic       hexp [8] = '{0, 1, 1, 0, 1, 0, 1, 0};
    int adv_cycles = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      s = idle();
      s.halt_req = hreq[c]; s.step_req = sreq[c];
      set_in(s); #2;
      checks++;
      if (ctl !== exp[c] || halted !== hexp[c]) begin
        errors++;
        $display("FAIL halt_step_cycle%0d ctl=%b halted=%b exp %b/%b", c, ctl, halted, exp[c], hexp[c]);
      end
      if (c < 7 && ctl == CTL_RUN) adv_cycles++;
      tick();
    end
    checks++;
    if (adv_cycles != 2) begin
      errors++; $display("FAIL halt_step_adv_cycles got=%0d exp=2", adv_cycles);
    end
  endtask

  task automatic test_enable_freeze();
    stim_t s;
    do_reset();
    s = idle();
    s.enable = 1'b0; s.halt_req = 1'b1; s.ex_redirect = 1'b1;
    set_in(s); #2;
    checks++;
    if (ctl !== CTL_FROZEN) begin
      errors++; $display("FAIL enable_freeze_ctl got=%b exp=%b", ctl, CTL_FROZEN);
    end
    tick();
    checks++;
    if (halted !== 1'b0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL enable_freeze_hold halted=%b flush=%0d exp 0/0", halted, flush_cnt);
    end
  endtask

  task automatic test_reset_mid_stall_and_step();
    stim_t s;
    do_reset();
    s = idle();
    s.id_rs1 = 5'd4; s.id_use_rs1 = 1'b1; s.ex_rd = 5'd4; s.ex_memread = 1'b1;
    set_in(s); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    set_in(idle()); #2;
    checks++;
    if (ctl !== CTL_RUN || stall_cnt !== 32'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall ctl=%b stall=%0d halted=%b", ctl, stall_cnt, halted);
    end
    // Enter STEP, then reset: without reset the next cycle would be HALT.
    s = idle(); s.halt_req = 1'b1;
    set_in(s); tick(); tick();
    s.step_req = 1'b1; set_in(s); tick();
    set_in(idle()); reset = 1'b1; tick(); reset = 1'b0;
    #2;
    checks++;
    if (ctl !== CTL_RUN || halted !== 1'b0) begin
      errors++; $display("FAIL reset_mid_step ctl=%b halted=%b exp %b/0", ctl, halted, CTL_RUN);
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    do_reset();
    s = idle();
    s.id_rs2 = 5'd9; s.id_use_rs2 = 1'b1; s.ex_rd = 5'd9; s.ex_memread = 1'b1;
    set_in(s);
    repeat (20) tick();
    s = idle(); s.id_redirect = 1'b1;
    set_in(s);
    repeat (18) tick();
    checks++;
    if (s_stall_cnt !== 4'hF || s_flush_cnt !== 4'hF) begin
      errors++; $display("FAIL saturate_small stall=%0d flush=%0d exp 15/15", s_stall_cnt, s_flush_cnt);
    end
    checks++;
    if (stall_cnt !== 32'd20 || flush_cnt !== 32'd18) begin
      errors++; $display("FAIL saturate_wide stall=%0d flush=%0d exp 20/18", stall_cnt, flush_cnt);
    end
  endtask

  // Reference model: pipeline mode plus event totals.
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

  function automatic logic uses(input stim_t s, input logic [4:0] r);
    if (r == 0) return 1'b0;
    return (s.id_use_rs1 && s.id_rs1 == r) || (s.id_use_rs2 && s.id_rs2 == r);
  endfunction

  task automatic test_random();
    stim_t s;
    int mode = M_RUN;
    int stalls = 0, flushes = 0;
    logic hold_halt = 1'b0;
    logic do_rst, can_go, must_wait;
    logic [6:0] exp_ctl;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) hold_halt = ~hold_halt;
      s.halt_req = hold_halt;
      s.step_req = ($urandom_range(0, 3) == 0);
      s.id_rs1 = 5'($urandom_range(0, 3)); s.id_rs2 = 5'($urandom_range(0, 3));
      s.id_use_rs1 = 1'($urandom); s.id_use_rs2 = 1'($urandom);
      s.id_branch = 1'($urandom); s.id_redirect = 1'($urandom);
      s.ex_redirect = ($urandom_range(0, 7) == 0);
      s.ex_rd = 5'($urandom_range(0, 3));
      s.ex_regwrite = 1'($urandom); s.ex_memread = 1'($urandom);
      s.mem_rd = 5'($urandom_range(0, 3)); s.mem_memread = 1'($urandom);
      do_rst = ($urandom_range(0, 99) == 0);
      set_in(s);
      reset = do_rst;

      can_go = s.enable && ((mode == M_RUN && !s.halt_req) || mode == M_STEP);
      must_wait = (s.ex_memread && uses(s, s.ex_rd)) ||
                  (s.id_branch && s.ex_regwrite && uses(s, s.ex_rd)) ||
                  (s.id_branch && s.mem_memread && uses(s, s.mem_rd));
      if (!can_go)            exp_ctl = CTL_FROZEN;
      else if (s.ex_redirect) exp_ctl = CTL_EXRED;
      else if (must_wait)     exp_ctl = CTL_STALL;
      else if (s.id_redirect) exp_ctl = CTL_IDRED;
      else                    exp_ctl = CTL_RUN;

      #2;
      checks++;
      if (ctl !== exp_ctl || s_ctl !== exp_ctl) begin
        errors++; $display("FAIL random_ctl n=%0d got=%b small=%b exp=%b", n, ctl, s_ctl, exp_ctl);
      end

      if (do_rst) begin
        mode = M_RUN; stalls = 0; flushes = 0;
      end else begin
        if (can_go && exp_ctl == CTL_STALL) stalls++;
        if (can_go && (exp_ctl == CTL_EXRED || exp_ctl == CTL_IDRED)) flushes++;
        if (s.enable) begin
          if (mode == M_STEP)                        mode = M_HALT;
          else if (mode == M_RUN && s.halt_req)      mode = M_HALT;
          else if (mode == M_HALT && !s.halt_req)    mode = M_RUN;
          else if (mode == M_HALT && s.step_req)     mode = M_STEP;
        end
      end
      tick();
      reset = 1'b0;

      checks++;
      if (halted !== (mode == M_HALT) || s_halted !== (mode == M_HALT) ||
          stall_cnt !== 32'(stalls) || flush_cnt !== 32'(flushes) ||
          s_stall_cnt !== 4'((stalls > 15) ? 15 : stalls) ||
          s_flush_cnt !== 4'((flushes > 15) ? 15 : flushes)) begin
        errors++;
        $display("FAIL random_state n=%0d halted=%b stall=%0d/%0d flush=%0d/%0d exp halted=%b stall=%0d flush=%0d",
                 n, halted, stall_cnt, s_stall_cnt, flush_cnt, s_flush_cnt,
                 (mode == M_HALT), stalls, flushes);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(idle());
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_branch_after_alu();
    test_ex_redirect_priority();
    test_x0_no_hazard();
    test_halt_step();
    test_enable_freeze();
    test_reset_mid_stall_and_step();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
